// File: rtl/tomasulo_cdb_arb.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg / tomasulo_cdb_arb
//
// Producer end of the Common Data Bus. Each functional unit hands over a
// completed result (tag + data) through a valid/ready port. Accepted results
// wait in a small per-FU circular FIFO. Every cycle a round-robin arbiter
// picks one non-empty FIFO. Its head result is driven onto the registered
// broadcast cdb_r for exactly one cycle.
//
// Ports
//   clk      clock
//   rst      synchronous active-high reset (drops all buffered results)
//   fu_vld   per-FU result valid
//   fu_tag   per-FU result tag, FU i in [i*TAG_W +: TAG_W]
//   fu_data  per-FU result data, FU i in [i*DATA_W +: DATA_W]
//   fu_rdy   per-FU ready. It is a register-only function of FIFO fullness,
//            so there is no combinational path from this cycle's pop.
//   cdb_r    registered broadcast {vld, tag, data}. Tag and data are 0
//            whenever vld is 0.
// ---------------------------------------------------------------------------
package tomasulo_pkg;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic                  vld;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;
endpackage

module tomasulo_cdb_arb #(
    parameter int N_FU      = 4,
    parameter int TAG_W     = 4,   // must match tomasulo_pkg::CDB_TAG_W
    parameter int DATA_W    = 32,  // must match tomasulo_pkg::CDB_DATA_W
    parameter int BUF_DEPTH = 2    // power of 2, >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_FU-1:0]        fu_vld,
    input  logic [N_FU*TAG_W-1:0]  fu_tag,
    input  logic [N_FU*DATA_W-1:0] fu_data,
    output logic [N_FU-1:0]        fu_rdy,
    output tomasulo_pkg::cdb_t     cdb_r
);
    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [N_FU-1:0]   full_vec;
    logic [N_FU-1:0]   req;
    logic [N_FU-1:0]   push;
    logic [N_FU-1:0]   pop;
    logic [TAG_W-1:0]  head_tag  [N_FU];
    logic [DATA_W-1:0] head_data [N_FU];

    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  rr_ptr_next;

    // Ready depends only on the registered full flag. A full FIFO therefore
    // refuses a push even in the cycle it is popped.
    assign fu_rdy = rst ? '0 : ~full_vec;
    assign push   = fu_vld & fu_rdy;

    // ------------------------------------------------------------------
    // Per-FU result FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_FU; gi++) begin : g_fifo
            logic [TAG_W-1:0]  tag_mem  [BUF_DEPTH];
            logic [DATA_W-1:0] data_mem [BUF_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic [CNT_W-1:0]  count_next;
            logic              full_reg;

            // Storage carries no reset; a stale entry is never read
            // because the occupancy count gates every pop.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    tag_mem[wr_ptr_reg]  <= fu_tag[gi*TAG_W +: TAG_W];
                    data_mem[wr_ptr_reg] <= fu_data[gi*DATA_W +: DATA_W];
                end
            end

            always_comb begin
                count_next = count_reg;
                if (push[gi] && !pop[gi]) begin
                    count_next = count_reg + CNT_W'(1);
                end else if (!push[gi] && pop[gi]) begin
                    count_next = count_reg - CNT_W'(1);
                end
            end

            // The pointers wrap naturally because BUF_DEPTH is a power of two.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    full_reg   <= 1'b0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_next;
                    full_reg  <= (count_next == CNT_W'(BUF_DEPTH));
                end
            end

            assign full_vec[gi]  = full_reg;
            assign req[gi]       = (count_reg != '0);
            assign head_tag[gi]  = tag_mem[rd_ptr_reg];
            assign head_data[gi] = data_mem[rd_ptr_reg];
            assign pop[gi]       = grant_vld && (grant_idx == IDX_W'(gi));

            a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                !(push[gi] && full_reg));
            a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
                !(pop[gi] && (count_reg == '0)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin grant. The search starts at rr_ptr_reg and wraps modulo
    // N_FU. The extra bit in cand absorbs rr_ptr_reg + k before the wrap.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDX_W:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_FU; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_FU)) begin
                cand = cand - (IDX_W+1)'(N_FU);
            end
            if (!grant_vld && req[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_vld) begin
            rr_ptr_next = (grant_idx == IDX_W'(N_FU-1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered broadcast
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            cdb_r      <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (grant_vld) begin
                cdb_r.vld  <= 1'b1;
                cdb_r.tag  <= head_tag[grant_idx];
                cdb_r.data <= head_data[grant_idx];
            end else begin
                cdb_r <= '0;
            end
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(pop));
    a_idle_zero: assert property (@(posedge clk) disable iff (rst)
        !cdb_r.vld |-> ((cdb_r.tag == '0) && (cdb_r.data == '0)));

endmodule
